// File: rtl/pico_mem_arbiter_pkg.sv
// Shared types and constants for the two-requester pico memory arbiter.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.

`ifndef L15_AMO_OP_WIDTH
`define L15_AMO_OP_WIDTH 4
`endif

package pico_mem_arb_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Requester identifier: 0 or 1
  typedef logic req_id_t;

  // Load data returned to a requester whose transaction timed out
  localparam logic [31:0] PICO_ARB_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/pico_mem_arbiter_rr_picker.sv
// Two-way round-robin picker: chooses a requester from the valid vector.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.

module pico_rr_picker
  import pico_mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    last_grant_i,
  output logic       grant_val_o,
  output req_id_t    grant_id_o
);

  // A lone requester always wins; with both pending the one not served last wins
  always_comb begin
    grant_val_o = |valid_i;
    grant_id_o  = 1'b0;
    case (valid_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pico_mem_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-style memory port between two requesters.
// Latency: 1 cycle arbitration, then the grant is held until the downstream ready pulse.
// Backpressure: requesters hold valid until their ready; optional timeout (PICO_MEM_ARB_TIMEOUT_EN).

module pico_mem_arbiter
  import pico_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RESET_PRIO     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m0_mem_valid,
  input  logic [31:0]                   m0_mem_addr,
  input  logic [3:0]                    m0_mem_wstrb,
  input  logic [31:0]                   m0_mem_wdata,
  input  logic [`L15_AMO_OP_WIDTH-1:0]  m0_mem_amo_op,
  output logic                          m0_mem_ready,
  output logic [31:0]                   m0_mem_rdata,
  input  logic                          m1_mem_valid,
  input  logic [31:0]                   m1_mem_addr,
  input  logic [3:0]                    m1_mem_wstrb,
  input  logic [31:0]                   m1_mem_wdata,
  input  logic [`L15_AMO_OP_WIDTH-1:0]  m1_mem_amo_op,
  output logic                          m1_mem_ready,
  output logic [31:0]                   m1_mem_rdata,
  output logic                          arb_transducer_mem_valid,
  output logic [31:0]                   arb_transducer_mem_addr,
  output logic [3:0]                    arb_transducer_mem_wstrb,
  output logic [31:0]                   arb_transducer_mem_wdata,
  output logic [`L15_AMO_OP_WIDTH-1:0]  arb_transducer_mem_amo_op,
  input  logic                          transducer_arb_mem_ready,
  input  logic [31:0]                   transducer_arb_mem_rdata,
  output logic                          arb_grant_id,
  output logic                          arb_busy,
  output logic                          arb_timeout_err
);

  localparam req_id_t LAST_GRANT_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

  arb_state_e  state_q, state_d;
  req_id_t     grant_id_q, grant_id_d;
  req_id_t     last_grant_q, last_grant_d;
  logic        pick_vld;
  req_id_t     pick_id;
  logic        cpl_vld;
  logic [31:0] cpl_rdata;
  logic        tmo_hit;

  pico_rr_picker u_picker (
    .valid_i      ({m1_mem_valid, m0_mem_valid}),
    .last_grant_i (last_grant_q),
    .grant_val_o  (pick_vld),
    .grant_id_o   (pick_id)
  );

`ifdef PICO_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign tmo_hit = (state_q == GRANT) && (cnt_q == TMO_LAST);

  // Counter is zero on the first GRANT cycle and advances every GRANT cycle;
  // a ready arriving on the expiry cycle wins, so the error flag is not raised then
  always_comb begin
    cnt_d = (state_q == GRANT) ? cnt_q + CNT_W'(1) : '0;
    err_d = err_q | (tmo_hit & ~transducer_arb_mem_ready);
  end

  // Timeout counter and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb_timeout_err = err_q;
`else
  assign tmo_hit         = 1'b0;
  assign arb_timeout_err = 1'b0;
`endif

  // Next-state logic: arbitrate in IDLE, complete on downstream ready or timeout
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    cpl_vld      = 1'b0;
    cpl_rdata    = 32'h0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick_id;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (transducer_arb_mem_ready) begin
          cpl_vld      = 1'b1;
          cpl_rdata    = transducer_arb_mem_rdata;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end else if (tmo_hit) begin
          cpl_vld      = 1'b1;
          cpl_rdata    = PICO_ARB_ERR_RDATA;
          last_grant_d = grant_id_q;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        // The late downstream response is absorbed here, never forwarded
        if (transducer_arb_mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Downstream fields follow the granted requester while a request is outstanding
  always_comb begin
    arb_transducer_mem_valid  = (state_q == GRANT) || (state_q == DRAIN);
    arb_transducer_mem_addr   = 32'h0;
    arb_transducer_mem_wstrb  = 4'h0;
    arb_transducer_mem_wdata  = 32'h0;
    arb_transducer_mem_amo_op = '0;
    if (arb_transducer_mem_valid) begin
      if (grant_id_q) begin
        arb_transducer_mem_addr   = m1_mem_addr;
        arb_transducer_mem_wstrb  = m1_mem_wstrb;
        arb_transducer_mem_wdata  = m1_mem_wdata;
        arb_transducer_mem_amo_op = m1_mem_amo_op;
      end else begin
        arb_transducer_mem_addr   = m0_mem_addr;
        arb_transducer_mem_wstrb  = m0_mem_wstrb;
        arb_transducer_mem_wdata  = m0_mem_wdata;
        arb_transducer_mem_amo_op = m0_mem_amo_op;
      end
    end
  end

  assign m0_mem_ready = cpl_vld & (grant_id_q == 1'b0);
  assign m1_mem_ready = cpl_vld & (grant_id_q == 1'b1);
  assign m0_mem_rdata = m0_mem_ready ? cpl_rdata : 32'h0;
  assign m1_mem_rdata = m1_mem_ready ? cpl_rdata : 32'h0;
  assign arb_grant_id = grant_id_q;
  assign arb_busy     = (state_q != IDLE);

  // Configuration sanity: the timeout must leave room to count, priority is a requester id
  a_cfg: assert property (@(posedge clk) disable iff (rst)
    (TIMEOUT_CYCLES >= 2) && (RESET_PRIO == 0 || RESET_PRIO == 1));

  // The granted requester must keep its request up until it is answered
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT) |-> (grant_id_q ? m1_mem_valid : m0_mem_valid));

  // A downstream response with nothing outstanding is a downstream protocol error
  a_stray_rdy: assert property (@(posedge clk) disable iff (rst)
    transducer_arb_mem_ready |-> (state_q != IDLE));

endmodule
